// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the two-digit 7-segment scan driver.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    SHOW0 = 2'd0,
    GAP0  = 2'd1,
    SHOW1 = 2'd2,
    GAP1  = 2'd3
  } scan_state_t;

  localparam logic [6:0] ZERO_PAT = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  // Maps an active-high pattern onto the physical polarity of the pins.
  function automatic logic [6:0] seg_polarity(input logic [6:0] lit, input bit active_low);
    return active_low ? ~lit : lit;
  endfunction

endpackage

// File: rtl/seg_scan_mux_prescaler.sv
// Modulo-REFRESH_DIV slot counter producing the end-of-slot and start-of-gap strobes.
module scan_prescaler #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic slot_end,
  output logic gap_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_AT = CW'(REFRESH_DIV - DEAD_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= slot_end ? '0 : count + CW'(1);
    end
  end

  // With no dead time both strobes land on the same count.
  assign slot_end  = (count == LAST);
  assign gap_start = (count == GAP_AT);

endmodule

// File: rtl/seg_scan_mux.sv
// Two-digit 7-segment scan driver: per-frame snapshot, dead-time gaps, leading-zero blanking.
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD_CYCLES    = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  digit1,
  input  logic [6:0]  digit0,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [1:0]  an,
  output logic        frame_start,
  output scan_state_t dbg_state
);

  localparam bit         NO_GAP   = (DEAD_CYCLES == 0);
  localparam logic [6:0] SEG_IDLE = seg_polarity(SEG_OFF, SEG_ACTIVE_LOW);
  localparam logic [1:0] AN_IDLE  = AN_ACTIVE_LOW ? 2'b11 : 2'b00;

  scan_state_t state_q, state_d;
  logic        run_q;
  logic [6:0]  snap1_q, snap0_q, snap1_d, snap0_d;
  logic        snap_lz_q, snap_lz_d;
  logic        load;
  logic        slot_end, gap_start;
  logic [6:0]  seg_lit;
  logic [1:0]  an_lit;

  scan_prescaler #(
    .REFRESH_DIV(REFRESH_DIV),
    .DEAD_CYCLES(DEAD_CYCLES)
  ) u_prescaler (
    .clock    (clock),
    .reset    (reset),
    .en       (run_q),
    .slot_end (slot_end),
    .gap_start(gap_start)
  );

  // run_q low means the first edge after reset: snapshot and show units without advancing.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (!run_q) begin
      load = 1'b1;
    end else begin
      case (state_q)
        SHOW0: if (gap_start) state_d = NO_GAP ? SHOW1 : GAP0;
        GAP0:  if (slot_end) state_d = SHOW1;
        SHOW1: begin
          if (gap_start) begin
            state_d = NO_GAP ? SHOW0 : GAP1;
            load    = NO_GAP;
          end
        end
        GAP1: begin
          if (slot_end) begin
            state_d = SHOW0;
            load    = 1'b1;
          end
        end
        default: state_d = SHOW0;
      endcase
    end
  end

  assign snap1_d   = load ? digit1   : snap1_q;
  assign snap0_d   = load ? digit0   : snap0_q;
  assign snap_lz_d = load ? blank_lz : snap_lz_q;

  // Output values are derived from the next state so they register alongside it.
  always_comb begin
    seg_lit = SEG_OFF;
    an_lit  = 2'b00;
    case (state_d)
      SHOW0: begin
        an_lit  = 2'b01;
        seg_lit = snap0_d;
      end
      SHOW1: begin
        if (!(snap_lz_d && (snap1_d == ZERO_PAT))) begin
          an_lit  = 2'b10;
          seg_lit = snap1_d;
        end
      end
      default: begin
        an_lit  = 2'b00;
        seg_lit = SEG_OFF;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= SHOW0;
      run_q       <= 1'b0;
      snap1_q     <= '0;
      snap0_q     <= '0;
      snap_lz_q   <= 1'b0;
      seg         <= SEG_IDLE;
      an          <= AN_IDLE;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      snap1_q     <= snap1_d;
      snap0_q     <= snap0_d;
      snap_lz_q   <= snap_lz_d;
      seg         <= seg_polarity(seg_lit, SEG_ACTIVE_LOW);
      an          <= AN_ACTIVE_LOW ? ~an_lit : an_lit;
      frame_start <= load;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: three parameterisations driven in parallel against a frame-arithmetic model.
module tb_seg_scan_mux;
  import seg_scan_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] digit1 = '0;
  logic [6:0] digit0 = '0;
  logic       blank_lz = 1'b0;

  logic [6:0]  seg_o [3];
  logic [1:0]  an_o [3];
  logic        fs_o [3];
  scan_state_t dbg_o [3];

  // Instance parameters: refresh, dead time, segment low-true, anode low-true.
  int rr  [3] = '{8, 4, 5};
  int dd  [3] = '{2, 0, 4};
  bit sal [3] = '{1'b1, 1'b1, 1'b0};
  bit aal [3] = '{1'b1, 1'b1, 1'b0};

  int vectors = 0;
  int miscompares = 0;
  int e = 0;
  int n_edges = 0;
  bit started = 1'b0;
  logic [6:0] m_d1 [3];
  logic [6:0] m_d0 [3];
  logic       m_lz [3];

  always #5 clock = ~clock;

  seg_scan_mux #(.REFRESH_DIV(8), .DEAD_CYCLES(2), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_a (
    .clock(clock), .reset(reset), .digit1(digit1), .digit0(digit0), .blank_lz(blank_lz),
    .seg(seg_o[0]), .an(an_o[0]), .frame_start(fs_o[0]), .dbg_state(dbg_o[0]));

  seg_scan_mux #(.REFRESH_DIV(4), .DEAD_CYCLES(0), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_b (
    .clock(clock), .reset(reset), .digit1(digit1), .digit0(digit0), .blank_lz(blank_lz),
    .seg(seg_o[1]), .an(an_o[1]), .frame_start(fs_o[1]), .dbg_state(dbg_o[1]));

  seg_scan_mux #(.REFRESH_DIV(5), .DEAD_CYCLES(4), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut_c (
    .clock(clock), .reset(reset), .digit1(digit1), .digit0(digit0), .blank_lz(blank_lz),
    .seg(seg_o[2]), .an(an_o[2]), .frame_start(fs_o[2]), .dbg_state(dbg_o[2]));

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: position within the 2R-edge frame decides which digit is shown.
  task automatic model_expect(input int k, output logic [6:0] es, output logic [1:0] ea, output logic ef);
    logic [6:0] lit;
    logic [1:0] en;
    int p, slot, off;
    lit = 7'd0;
    en  = 2'b00;
    ef  = 1'b0;
    if (n_edges > 0) begin
      p    = (n_edges - 1) % (2 * rr[k]);
      slot = p / rr[k];
      off  = p % rr[k];
      ef   = (p == 0);
      if (off < rr[k] - dd[k]) begin
        if (slot == 0) begin
          en  = 2'b01;
          lit = m_d0[k];
        end else if (!(m_lz[k] && m_d1[k] == 7'b0111111)) begin
          en  = 2'b10;
          lit = m_d1[k];
        end
      end
    end
    es = sal[k] ? ~lit : lit;
    ea = aal[k] ? ~en : en;
  endtask

  always @(posedge clock) begin
    started = 1'b1;
    if (reset) begin
      n_edges = 0;
      for (int k = 0; k < 3; k++) begin
        m_d1[k] = '0;
        m_d0[k] = '0;
        m_lz[k] = 1'b0;
      end
    end else begin
      n_edges++;
      for (int k = 0; k < 3; k++) begin
        if ((n_edges - 1) % (2 * rr[k]) == 0) begin
          m_d1[k] = digit1;
          m_d0[k] = digit0;
          m_lz[k] = blank_lz;
        end
      end
    end
  end

  always @(negedge clock) begin
    logic [6:0] es;
    logic [1:0] ea;
    logic       ef;
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        model_expect(k, es, ea, ef);
        chk($sformatf("model inst%0d {seg,an,fs}", k),
            16'({seg_o[k], an_o[k], fs_o[k]}), 16'({es, ea, ef}));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    e++;
  endtask

  task automatic step_to(input int t);
    while (e < t) step();
  endtask

  task automatic release_reset();
    reset = 1'b0;
    e = 0;
  endtask

  initial begin
    reset    = 1'b1;
    digit0   = 7'b0000110;
    digit1   = 7'b1011011;
    blank_lz = 1'b0;
    step();
    step();
    chk("reset an", 16'(an_o[0]), 16'(2'b11));
    chk("reset seg", 16'(seg_o[0]), 16'(7'b1111111));
    chk("reset fs", 16'(fs_o[0]), 16'(1'b0));
    chk("reset an active-high", 16'(an_o[2]), 16'(2'b00));
    release_reset();

    step_to(1);
    chk("e1 an", 16'(an_o[0]), 16'(2'b10));
    chk("e1 seg", 16'(seg_o[0]), 16'(7'b1111001));
    chk("e1 fs", 16'(fs_o[0]), 16'(1'b1));
    chk("e1 c seg active-high", 16'(seg_o[2]), 16'(7'b0000110));
    step_to(2);
    chk("e2 fs", 16'(fs_o[0]), 16'(1'b0));
    digit0 = 7'b1101101;
    step_to(5);
    chk("d0 e5 an b", 16'(an_o[1]), 16'(2'b01));
    step_to(7);
    chk("e7 an", 16'(an_o[0]), 16'(2'b11));
    chk("e7 seg", 16'(seg_o[0]), 16'(7'b1111111));
    step_to(9);
    chk("e9 an", 16'(an_o[0]), 16'(2'b01));
    chk("e9 seg", 16'(seg_o[0]), 16'(7'b0100100));
    chk("d0 e9 fs b", 16'(fs_o[1]), 16'(1'b1));
    step_to(16);
    chk("e16 fs", 16'(fs_o[0]), 16'(1'b0));
    step_to(17);
    chk("e17 fs", 16'(fs_o[0]), 16'(1'b1));
    chk("e17 seg new digit0", 16'(seg_o[0]), 16'(7'b0010010));

    digit1   = ZERO_PAT;
    blank_lz = 1'b1;
    step_to(41);
    chk("lz on an", 16'(an_o[0]), 16'(2'b11));
    chk("lz on seg", 16'(seg_o[0]), 16'(7'b1111111));
    blank_lz = 1'b0;
    step_to(57);
    chk("lz off an", 16'(an_o[0]), 16'(2'b01));
    chk("lz off seg", 16'(seg_o[0]), 16'(7'b1000000));

    reset = 1'b1;
    step();
    digit0 = 7'b1001111;
    release_reset();
    step_to(10);
    reset = 1'b1;
    step();
    chk("mid reset an", 16'(an_o[0]), 16'(2'b11));
    chk("mid reset seg", 16'(seg_o[0]), 16'(7'b1111111));
    chk("mid reset fs", 16'(fs_o[0]), 16'(1'b0));
    step();
    release_reset();
    step_to(1);
    chk("restart fs", 16'(fs_o[0]), 16'(1'b1));
    chk("restart an", 16'(an_o[0]), 16'(2'b10));
    chk("restart seg", 16'(seg_o[0]), 16'(7'b0110000));
    step_to(7);
    chk("restart e7 an", 16'(an_o[0]), 16'(2'b11));
    step_to(9);
    chk("restart e9 an", 16'(an_o[0]), 16'(2'b01));

    for (int i = 0; i < 400; i++) begin
      digit0   = 7'($urandom_range(0, 127));
      digit1   = ($urandom_range(0, 1) == 1) ? ZERO_PAT : 7'($urandom_range(0, 127));
      blank_lz = 1'($urandom_range(0, 1));
      reset    = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Time-multiplexed driver for a two-digit common-anode/common-cathode 7-segment display, sitting directly downstream of the two-digit counter. It takes the counter's two 7-bit segment patterns (`digit1`, `digit0`), snapshots them once per refresh frame, and drives one shared segment bus plus two digit enables. A dead-time gap between digits suppresses ghosting. Optional leading-zero blanking is applied to the tens digit.

## Interface
Parameters:
- `REFRESH_DIV`, 50000: clock cycles per digit slot (show plus gap); legal range 2..2^20.
- `DEAD_CYCLES`, 16: blanked cycles at the end of each slot; legal range 0..REFRESH_DIV-1.
- `SEG_ACTIVE_LOW`, 1: 1 means `seg` is driven low-true.
- `AN_ACTIVE_LOW`, 1: 1 means `an` is driven low-true.

Ports:
- `clock`, in, 1: single system clock.
- `reset`, in, 1: synchronous, active-high.
- `digit1`, in, 7: tens pattern; bit6=g … bit0=a; input is always active-high (1 = segment lit).
- `digit0`, in, 7: units pattern; same encoding as `digit1`.
- `blank_lz`, in, 1: enables leading-zero blanking of `digit1`.
- `seg`, out, 7: shared segment bus, same bit order, polarity set by `SEG_ACTIVE_LOW`.
- `an`, out, 2: digit enables; `an[1]` = tens, `an[0]` = units; polarity set by `AN_ACTIVE_LOW`.
- `frame_start`, out, 1: one-cycle pulse marking a new frame snapshot.

## Operation
- FSM states: SHOW0, GAP0, SHOW1, GAP1, cycled in that order.
  - SHOW length: `REFRESH_DIV - DEAD_CYCLES` cycles.
  - GAP length: `DEAD_CYCLES` cycles.
  - If `DEAD_CYCLES` = 0, the GAP states are skipped entirely.
- Frame snapshot: on the edge that enters SHOW0, both `digit1` and `digit0` are captured together. This keeps each frame coherent, so a counter rollover never tears across digits.
- SHOW0: `an[0]` active, `an[1]` inactive, `seg` = snapshot of `digit0`.
- SHOW1: `an[1]` active, `an[0]` inactive, `seg` = snapshot of `digit1`.
- Leading-zero blanking: in SHOW1, if the snapshot of `blank_lz` is 1 and the `digit1` snapshot equals ZERO_PAT (7'b0111111), both `an` bits are inactive and `seg` is all-off. `blank_lz` is captured with the frame snapshot.
- GAP0/GAP1: both `an` bits inactive, `seg` all-off.
- Polarity: "active/lit" maps to 0 when the corresponding `*_ACTIVE_LOW` = 1, otherwise to 1.
- All outputs are registered; there is no combinational input-to-output path.

## Timing
- Reset values (while `reset`=1): state = SHOW0, slot counter = 0, snapshots = 0, `an` all inactive, `seg` all-off, `frame_start` = 0.
- Edge numbering: edge 1 is the first rising edge sampled with `reset`=0.
  - Edge 1 takes the snapshot and sets `frame_start`=1 for exactly one cycle.
  - From edge 1, `an[0]`/`seg` show units.
  - After that, a snapshot occurs every `2*REFRESH_DIV` edges (edges 1, 1+2R, 1+4R, …).
- Example, `REFRESH_DIV`=8, `DEAD_CYCLES`=2:
  - Outputs after edges 1–6: SHOW0.
  - Edges 7–8: GAP0.
  - Edges 9–14: SHOW1.
  - Edges 15–16: GAP1.
  - Edge 17: next snapshot.
- Input changes between snapshots have no effect until the next `frame_start`.
- Reset mid-slot: the next edge with `reset`=1 forces the reset values. Restart then follows the edge-1 rule.
- Slot counter width: `$clog2(REFRESH_DIV)`. The counter wraps to 0 at `REFRESH_DIV-1` and never exceeds that value.

## Structure
- Package `seg_scan_pkg`:
  - `scan_state_t` enum (SHOW0, GAP0, SHOW1, GAP1).
  - `ZERO_PAT` = 7'b0111111.
  - `SEG_OFF` = 7'b0000000 (pre-polarity).
- Sub-module `scan_prescaler`:
  - Parameterized modulo-`REFRESH_DIV` counter.
  - Outputs `slot_end` (count = `REFRESH_DIV-1`) and `gap_start` (count = `REFRESH_DIV-DEAD_CYCLES-1`).
  - The FSM consumes these strobes.
- Top level: FSM, snapshot registers, polarity muxing, output registers.

## Test plan
- Reset release, R=8, D=2, `digit0`=7'b0000110, `digit1`=7'b1011011, both polarities low:
  - After edge 1: `an`=2'b10, `seg`=7'b1111001, `frame_start`=1 for one cycle.
  - After edge 7: `an`=2'b11, `seg`=7'b1111111.
  - After edge 9: `an`=2'b01, `seg`=7'b0100100.
- Snapshot coherence: change `digit0` at edge 3 (mid-SHOW0):
  - `seg` is unchanged through edge 16.
  - The new value appears after edge 17.
- Leading-zero blanking: `digit1`=ZERO_PAT, `blank_lz`=1.
  - SHOW1 cycles have `an`=2'b11.
  - With `blank_lz`=0, the same cycles have `an`=2'b01 and `seg`=7'b1000000.
- `DEAD_CYCLES`=0, R=4:
  - `an` alternates 2'b10 for 4 cycles, then 2'b01 for 4 cycles, with no all-off cycle.
  - `frame_start` every 8 cycles.
- Reset asserted at edge 11 (SHOW1) for 2 cycles:
  - Outputs are inactive during reset.
  - `frame_start` is seen on the first edge after deassert.
  - The SHOW0 timing repeats exactly as in the first scenario.
